// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Issues one 16-bit fetch per cycle to a request/valid instruction memory,
// absorbs a decode stall with a one-entry skid register, handles EX/MEM
// redirects (including one that lands while a request is still outstanding),
// and stops fetching after a HALT word (opcode [15:11] == 5'b00000).
//
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous active-low reset
//   stallCtrl           decode hazard stall: hold PC and IF/ID
//   takeBranch_EXMEM    redirect request (highest priority)
//   branchTarget_EXMEM  redirect address
//   imem_req/imem_addr  fetch request and address
//   imem_valid/rdata    response; completes the request in that cycle
//   instr_IFID, PC2_IFID, halt_IFID, valid_IFID   IF/ID register
//   err                 sticky misaligned-redirect error
//   stallCnt            (FETCH_PERF_CNT_EN only) saturating stall counter
//
// Optional feature: define FETCH_PERF_CNT_EN to add the stallCnt output.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallCtrl,
    input  logic        takeBranch_EXMEM,
    input  logic [15:0] branchTarget_EXMEM,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_IFID,
    output logic [15:0] PC2_IFID,
    output logic        halt_IFID,
    output logic        valid_IFID,
    output logic        err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] stallCnt
`endif
);

    typedef enum logic [1:0] {FETCH, HOLD, FLUSH, HALTED} state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        halt;
        logic        valid;
    } ifid_t;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] flush_addr_q, flush_addr_d;  // address of the request being drained in FLUSH
    logic [15:0] skid_q, skid_d;              // occupied exactly while in HOLD
    ifid_t       ifid_q, ifid_d;
    logic        err_q, err_d;
    logic        ready_q;                     // low for the first cycle after reset release

    logic [15:0] pc_plus2;
    logic        rdata_halt;
    logic        skid_halt;

    assign pc_plus2   = pc_q + 16'd2;  // 16-bit modulo wrap is intended
    assign rdata_halt = (imem_rdata[15:11] == 5'b00000);
    assign skid_halt  = (skid_q[15:11] == 5'b00000);

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        flush_addr_d = flush_addr_q;
        skid_d       = skid_q;
        ifid_d       = ifid_q;
        err_d        = err_q;
        imem_req     = 1'b0;
        imem_addr    = pc_q;

        case (state_q)
            FETCH:   imem_req = ready_q;
            FLUSH: begin
                imem_req  = 1'b1;
                imem_addr = flush_addr_q;
            end
            default: imem_req = 1'b0;
        endcase

        if (takeBranch_EXMEM) begin
            // Redirect beats stall in every state. Leaving HOLD drops the skid word.
            ifid_d = '{NOP_INSTR, ifid_q.pc2, 1'b0, 1'b0};
            pc_d   = {branchTarget_EXMEM[15:1], 1'b0};
            err_d  = err_q | branchTarget_EXMEM[0];
            if (state_q == FETCH && imem_req && !imem_valid) begin
                state_d      = FLUSH;
                flush_addr_d = pc_q;
            end else if (state_q == FLUSH && !imem_valid) begin
                // The drained request is still outstanding; keep its address.
                state_d = FLUSH;
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (!ready_q) begin
                        // Stray response straight after reset: ignored.
                        state_d = FETCH;
                    end else if (imem_valid) begin
                        if (stallCtrl) begin
                            skid_d  = imem_rdata;
                            state_d = HOLD;
                        end else begin
                            ifid_d = '{imem_rdata, pc_plus2, rdata_halt, 1'b1};
                            pc_d   = pc_plus2;
                            if (rdata_halt) state_d = HALTED;
                        end
                    end else if (!stallCtrl) begin
                        ifid_d = '{NOP_INSTR, ifid_q.pc2, 1'b0, 1'b0};
                    end
                end
                HOLD: begin
                    if (!stallCtrl) begin
                        ifid_d  = '{skid_q, pc_plus2, skid_halt, 1'b1};
                        pc_d    = pc_plus2;
                        state_d = skid_halt ? HALTED : FETCH;
                    end
                end
                FLUSH: begin
                    if (!stallCtrl) ifid_d = '{NOP_INSTR, ifid_q.pc2, 1'b0, 1'b0};
                    if (imem_valid) state_d = FETCH;
                end
                default: begin  // HALTED: PC frozen, only a redirect leaves
                    if (!stallCtrl) ifid_d = '{NOP_INSTR, ifid_q.pc2, 1'b0, 1'b0};
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            flush_addr_q <= 16'h0000;
            skid_q       <= NOP_INSTR;
            ifid_q       <= '{NOP_INSTR, 16'h0000, 1'b0, 1'b0};
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            flush_addr_q <= flush_addr_d;
            skid_q       <= skid_d;
            ifid_q       <= ifid_d;
            err_q        <= err_d;
            ready_q      <= 1'b1;
        end
    end

    assign instr_IFID = ifid_q.instr;
    assign PC2_IFID   = ifid_q.pc2;
    assign halt_IFID  = ifid_q.halt;
    assign valid_IFID = ifid_q.valid;
    assign err        = err_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0000;
        end else if ((stallCtrl || state_q == FLUSH) && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage -- directed self-checking bench for fetch_stage.
// Memory model: word at address a is 16'h4000, or 16'h4000 | a[10:0] in
// pattern mode, or 16'h0000 (HALT) at 16'h0030 when halt_en is set.
// Zero-wait mode answers every request in the same cycle; otherwise
// imem_valid is driven directly by the stimulus.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallCtrl;
    logic        takeBranch_EXMEM;
    logic [15:0] branchTarget_EXMEM;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic [15:0] instr_IFID;
    logic [15:0] PC2_IFID;
    logic        halt_IFID;
    logic        valid_IFID;
    logic        err;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stallCnt;
`endif

    logic zero_wait, valid_drv, pat, halt_en;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] word_at(input logic [15:0] a, input logic p, input logic h);
        if (h && a == 16'h0030) return 16'h0000;
        if (p) return 16'h4000 | {5'b00000, a[10:0]};
        return 16'h4000;
    endfunction

    assign imem_valid = zero_wait ? imem_req : valid_drv;
    assign imem_rdata = word_at(imem_addr, pat, halt_en);

    fetch_stage dut (
        .clk                (clk),
        .rst                (rst),
        .stallCtrl          (stallCtrl),
        .takeBranch_EXMEM   (takeBranch_EXMEM),
        .branchTarget_EXMEM (branchTarget_EXMEM),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_valid         (imem_valid),
        .imem_rdata         (imem_rdata),
        .instr_IFID         (instr_IFID),
        .PC2_IFID           (PC2_IFID),
        .halt_IFID          (halt_IFID),
        .valid_IFID         (valid_IFID),
        .err                (err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stallCnt           (stallCnt)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [15:0] target);
        takeBranch_EXMEM   = 1'b1;
        branchTarget_EXMEM = target;
        step();
        takeBranch_EXMEM   = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        zero_wait = 1'b0;
        valid_drv = 1'b1;  // stray valid during and right after reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   imem_req,   16'h0);
        check("rst_instr", instr_IFID, 16'h0800);
        check("rst_pc2",   PC2_IFID,   16'h0000);
        check("rst_halt",  halt_IFID,  16'h0);
        check("rst_valid", valid_IFID, 16'h0);
        check("rst_err",   err,        16'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_rst_ignore_valid", valid_IFID, 16'h0);
        check("post_rst_req",          imem_req,   16'h1);
        check("post_rst_addr",         imem_addr,  16'h0000);
        zero_wait = 1'b1;
        valid_drv = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stallCtrl          = 1'b0;
        takeBranch_EXMEM   = 1'b0;
        branchTarget_EXMEM = 16'h0000;
        pat                = 1'b0;
        halt_en            = 1'b0;
        do_reset();

        // Zero-wait streaming of 16'h4000.
        step();
        check("zw_instr0", instr_IFID, 16'h4000);
        check("zw_pc2_0",  PC2_IFID,   16'h0002);
        check("zw_valid0", valid_IFID, 16'h1);
        step();
        check("zw_pc2_1",  PC2_IFID,   16'h0004);
        step();
        check("zw_pc2_2",  PC2_IFID,   16'h0006);
        check("zw_instr2", instr_IFID, 16'h4000);

        // Stall with a response in flight at 0x0010.
        pat = 1'b1;
        redirect(16'h000E);
        check("br_bubble_valid", valid_IFID, 16'h0);
        check("br_bubble_instr", instr_IFID, 16'h0800);
        step();
        check("pre_stall_instr", instr_IFID, 16'h400E);
        check("pre_stall_pc2",   PC2_IFID,   16'h0010);
        stallCtrl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_req",   imem_req,   16'h0);
            check("stall_instr", instr_IFID, 16'h400E);
            check("stall_pc2",   PC2_IFID,   16'h0010);
            check("stall_valid", valid_IFID, 16'h1);
        end
        stallCtrl = 1'b0;
        step();
        check("skid_instr", instr_IFID, 16'h4010);
        check("skid_pc2",   PC2_IFID,   16'h0012);
        step();
        check("after_skid_instr", instr_IFID, 16'h4012);
        check("after_skid_pc2",   PC2_IFID,   16'h0014);

        // Redirect while a 3-cycle-latency request at 0x0020 is pending.
        redirect(16'h0020);
        zero_wait = 1'b0;
        valid_drv = 1'b0;
        check("lat_addr0", imem_addr, 16'h0020);
        takeBranch_EXMEM   = 1'b1;
        branchTarget_EXMEM = 16'h0100;
        step();
        takeBranch_EXMEM = 1'b0;
        check("flush_addr1", imem_addr, 16'h0020);
        check("flush_req1",  imem_req,  16'h1);
        step();
        check("flush_addr2", imem_addr, 16'h0020);
        valid_drv = 1'b1;
        step();
        check("flush_drop_valid", valid_IFID, 16'h0);
        check("flush_drop_instr", instr_IFID, 16'h0800);
        check("flush_new_addr",   imem_addr,  16'h0100);
        valid_drv = 1'b0;
        zero_wait = 1'b1;
        step();
        check("flush_next_instr", instr_IFID, 16'h4100);
        check("flush_next_pc2",   PC2_IFID,   16'h0102);

        // HALT at 0x0030.
        halt_en = 1'b1;
        redirect(16'h0030);
        step();
        check("halt_flag",  halt_IFID,  16'h1);
        check("halt_instr", instr_IFID, 16'h0000);
        check("halt_pc2",   PC2_IFID,   16'h0032);
        check("halt_req",   imem_req,   16'h0);
        step();
        check("halted_flag",  halt_IFID,  16'h0);
        check("halted_valid", valid_IFID, 16'h0);
        check("halted_pc",    imem_addr,  16'h0032);
        step();
        check("halted_req2", imem_req,  16'h0);
        check("halted_pc2",  imem_addr, 16'h0032);
        redirect(16'h0040);
        check("resume_req",  imem_req,  16'h1);
        check("resume_addr", imem_addr, 16'h0040);
        step();
        check("resume_instr", instr_IFID, 16'h4040);
        check("resume_pc2",   PC2_IFID,   16'h0042);
        halt_en = 1'b0;

        // Misaligned redirect.
        redirect(16'h0105);
        check("mis_err",  err,       16'h1);
        check("mis_addr", imem_addr, 16'h0104);
        step();
        check("mis_err_held", err,        16'h1);
        check("mis_instr",    instr_IFID, 16'h4104);
        check("mis_pc2",      PC2_IFID,   16'h0106);

        // Asynchronous reset in the middle of an active request.
        rst = 1'b0;
        #1;
        check("async_err",   err,        16'h0);
        check("async_req",   imem_req,   16'h0);
        check("async_valid", valid_IFID, 16'h0);
        check("async_addr",  imem_addr,  16'h0000);
        do_reset();

        // PC wrap at the top of the address space.
        redirect(16'hFFFE);
        step();
        check("wrap_instr", instr_IFID, 16'h47FE);
        check("wrap_pc2",   PC2_IFID,   16'h0000);
        check("wrap_addr",  imem_addr,  16'h0000);
        check("wrap_err",   err,        16'h0);

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        check("cnt_reset", stallCnt, 16'h0000);
        stallCtrl = 1'b1;
        repeat (5) step();
        stallCtrl = 1'b0;
        check("cnt_five", stallCnt, 16'h0005);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
